// File: rtl/timer_bank.sv
// timer_bank: bank of NCH independent programmable timers.
// Each channel has a loadable period and mode (one-shot or periodic), and
// start/stop strobes. Each channel drives a level line, a one-cycle expiry
// pulse and a busy flag. Counters advance only on cycles where i_en is high.
module timer_bank #(
  parameter  int NCH            = 4,
  parameter  int WIDTH          = 16,
  parameter  int DEFAULT_PERIOD = 255,
  localparam int CHW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CHW-1:0]   i_load_ch,
  input  logic [WIDTH-1:0] i_load_period,
  input  logic             i_load_periodic,
  input  logic [NCH-1:0]   i_start,
  input  logic [NCH-1:0]   i_stop,
  output logic [NCH-1:0]   o_line,
  output logic [NCH-1:0]   o_pulse,
  output logic [NCH-1:0]   o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q  [NCH];
  state_t           state_d  [NCH];
  logic [WIDTH-1:0] count_q  [NCH];
  logic [WIDTH-1:0] count_d  [NCH];
  logic [WIDTH-1:0] period_q [NCH];
  logic [WIDTH-1:0] period_d [NCH];
  logic [NCH-1:0]   periodic_q;
  logic [NCH-1:0]   periodic_d;
  logic [NCH-1:0]   line_d;
  logic [NCH-1:0]   pulse_d;
  logic [NCH-1:0]   busy_d;

  // Next-state for every channel: stop beats start, start beats counting;
  // a load to this channel only rewrites period/mode, never state or count.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k]    = state_q[k];
      count_d[k]    = count_q[k];
      period_d[k]   = period_q[k];
      periodic_d[k] = periodic_q[k];
      line_d[k]     = o_line[k];
      pulse_d[k]    = 1'b0;

      if (i_stop[k]) begin
        state_d[k] = IDLE;
        count_d[k] = '0;
      end else if (i_start[k]) begin
        state_d[k] = RUN;
        count_d[k] = '0;
        if (!periodic_q[k]) begin
          line_d[k] = 1'b0;
        end
      end else if (state_q[k] == RUN && i_en) begin
        if (count_q[k] >= period_q[k]) begin
          pulse_d[k] = 1'b1;
          if (periodic_q[k]) begin
            line_d[k]  = ~o_line[k];
            count_d[k] = '0;
          end else begin
            line_d[k]  = 1'b1;
            state_d[k] = DONE;
          end
        end else begin
          count_d[k] = count_q[k] + 1'b1;
        end
      end

      if (i_load && (32'(i_load_ch) == k)) begin
        period_d[k]   = i_load_period;
        periodic_d[k] = i_load_periodic;
      end

      busy_d[k] = (state_d[k] == RUN);
    end
  end

  // Channel registers; reset restores periods and modes as well as counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= IDLE;
        count_q[k]  <= '0;
        period_q[k] <= WIDTH'(DEFAULT_PERIOD);
      end
      periodic_q <= '0;
      o_line     <= '0;
      o_pulse    <= '0;
      o_busy     <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= state_d[k];
        count_q[k]  <= count_d[k];
        period_q[k] <= period_d[k];
      end
      periodic_q <= periodic_d;
      o_line     <= line_d;
      o_pulse    <= pulse_d;
      o_busy     <= busy_d;
    end
  end

endmodule
